cpu_io_responder: RTL
=====================

Name: cpu_io_responder

Overview:
Device-side responder for the CPU controller's I/O strobes.
- OUT path: accepts the accumulator byte whenever the controller asserts outen. Buffers it in a small FIFO and drains it to an external sink over a valid/ready handshake.
- IN path: captures one byte from an external source into a holding register. The holding register feeds the CPU's IN datapath mux and is released when the controller acknowledges consumption.

Parameters:
DATA_W, 8, width of the CPU data path and of every byte port.
DEPTH, 4, OUT FIFO entries; power of two, at least 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
outen  input  1  controller OUT strobe; single-cycle push request.
a_data  input  DATA_W  accumulator value, sampled when outen=1.
tx_valid  output  1  OUT FIFO not empty.
tx_data  output  DATA_W  head of the OUT FIFO.
tx_ready  input  1  sink accepts the byte when tx_valid & tx_ready.
out_full  output  1  OUT FIFO full.
out_ovf  output  1  sticky flag: an outen was dropped.
rx_valid  input  1  source presents rx_data.
rx_data  input  DATA_W  input byte.
rx_ready  output  1  holding register empty.
in_valid  output  1  holding register holds a byte.
in_data  output  DATA_W  held byte, drives the CPU IN mux.
in_ack  input  1  controller executed IN; releases the holding register.

Behaviour:
- Reset: reset_n low clears all state asynchronously.
  - Output values during reset: tx_valid=0, tx_data=0, out_full=0, out_ovf=0, rx_ready=1, in_valid=0, in_data=0.
  - Internal state during reset: FIFO pointers=0, count=0, input FSM=IDLE.
  - Reset mid-transfer discards all buffered bytes. There is no partial handshake after reset deasserts.
- OUT FIFO:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
  - push = outen & (!out_full | pop); pop = tx_valid & tx_ready.
  - Simultaneous push and pop: the count is unchanged and both pointers advance. This is legal when full, and the incoming byte is accepted.
  - Simultaneous push and pop when empty: pop=0 because tx_valid=0, so only the push happens.
  - outen while full without a pop: the byte is dropped and out_ovf is set on the next edge. out_ovf stays set until reset.
  - tx_data is read combinationally from the head entry. It is 0 while empty, and it stays stable while tx_valid=1 and tx_ready=0.
  - Push-to-tx_valid latency is 1 cycle.
  - out_full = (count==DEPTH); tx_valid = (count!=0).
- IN holding register, 2-state FSM:
  - IDLE: rx_ready=1, in_valid=0. If rx_valid=1, capture rx_data into in_data and go to FULL.
  - FULL: rx_ready=0, in_valid=1. If in_ack=1, go to IDLE; in_data keeps its last value. rx_valid is ignored.
  - in_ack in IDLE is ignored; no state change.
  - A refill takes at least one IDLE cycle after an ack, so the throughput is 1 byte per 2 cycles.
  - in_data stays constant while in FULL.
- The OUT and IN paths are fully independent. Every event on both paths in the same cycle is processed.

Optional Feature:
Macro IO_TXCOUNT_EN.
- Defined: adds output port tx_count, width 16. It counts accepted pops, resets to 0, and wraps from 0xFFFF to 0.
- Undefined: the port and the counter do not exist; behaviour is otherwise identical.

Decomposition:
- Package io_pkg holds:
  - the DATA_W default;
  - the input FSM state typedef (IDLE, FULL);
  - constant TXCOUNT_W=16.
- One sub-module, io_sync_fifo, parameterised by DATA_W and DEPTH. It contains the storage, pointers, count, full/empty logic and the push/pop qualification.
- The top level instantiates io_sync_fifo and adds out_ovf, the IN FSM and the optional counter.

Test Plan:
- Reset then push: reset_n low for 2 cycles, check all outputs at reset values. Pulse outen with a_data=8'hA5 and tx_ready=0 → tx_valid=1 and tx_data=8'hA5 on the next cycle.
- Fill and overflow: 4 outen pushes of 01,02,03,04 with tx_ready=0 → out_full=1. A 5th push of 8'h05 → dropped and out_ovf=1. Set tx_ready=1 → bytes drain 01,02,03,04, then tx_valid=0; out_ovf stays 1.
- Full with simultaneous push and pop: FIFO full with 10..13, outen with 8'h14 and tx_ready=1 in the same cycle → 10 popped, count stays 4, out_ovf stays 0. Draining then gives 11,12,13,14.
- Pointer wrap: stream 20 bytes 00..13 with tx_ready toggled every cycle and outen every cycle but never while full → output order is exactly 00..13 with no loss.
- IN path: rx_valid=1 with rx_data=8'h3C → next cycle in_valid=1, in_data=3C, rx_ready=0. Change rx_data to 8'h77 → in_data stays 3C. in_ack=1 → IDLE next cycle; the following cycle captures 77.
- Reset mid-operation: 2 bytes in the FIFO and in_valid=1, pulse reset_n low asynchronously between edges → outputs clear immediately. With IO_TXCOUNT_EN defined, tx_count=0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the CPU I/O responder: default byte width, IN-path state type, counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package io_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int TXCOUNT_W  = 16;

  // Holding-register state: IDLE accepts a byte from the source, FULL presents it to the CPU.
  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } in_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO of DEPTH x DATA_W entries with a combinational head read (0 while empty).
// Latency: a pushed byte appears at rd_data with rd_vld one cycle after the push edge.
// Backpressure: push_req is refused while full unless a pop is accepted in the same cycle.
module io_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop_req,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data,
  output logic              full
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push;
  logic              pop;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside a pop.
  assign full    = (count == FULL_CNT);
  assign rd_vld  = (count != '0);
  assign pop     = rd_vld & pop_req;
  assign push    = push_req & (~full | pop);
  assign rd_data = rd_vld ? mem[rd_ptr] : '0;

  // Storage: write the tail entry on every accepted push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap modulo DEPTH; count only moves when exactly one of push/pop happens.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_io_responder.sv
// CPU I/O responder: OUT strobes fill a FIFO drained by valid/ready; IN bytes go through a holding register.
// Latency: outen to tx_valid 1 cycle; rx_valid to in_valid 1 cycle; refill needs one IDLE cycle after in_ack.
// Backpressure: outen while full with no pop is dropped (sticky out_ovf); rx_ready low while holding. Macro IO_TXCOUNT_EN adds tx_count.
module cpu_io_responder
  import io_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
`ifdef IO_TXCOUNT_EN
  output logic [TXCOUNT_W-1:0] tx_count,
`endif
  input  logic                 outen,
  input  logic [DATA_W-1:0]    a_data,
  output logic                 tx_valid,
  output logic [DATA_W-1:0]    tx_data,
  input  logic                 tx_ready,
  output logic                 out_full,
  output logic                 out_ovf,
  input  logic                 rx_valid,
  input  logic [DATA_W-1:0]    rx_data,
  output logic                 rx_ready,
  output logic                 in_valid,
  output logic [DATA_W-1:0]    in_data,
  input  logic                 in_ack
);

  in_state_t state;
  in_state_t state_nxt;
  logic      capture;
  logic      tx_pop;

  assign tx_pop = tx_valid & tx_ready;

  io_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_req (outen),
    .wr_data  (a_data),
    .pop_req  (tx_ready),
    .rd_vld   (tx_valid),
    .rd_data  (tx_data),
    .full     (out_full)
  );

  // Sticky overflow: an OUT strobe arrived while full and no pop made room for it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_ovf <= 1'b0;
    end else if (outen && out_full && !tx_pop) begin
      out_ovf <= 1'b1;
    end
  end

  // IN FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // IN FSM next state and handshake outputs; rx_valid is ignored while holding, in_ack while empty.
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    in_valid  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          capture   = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        in_valid = 1'b1;
        if (in_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Holding register: loads only on capture, so it keeps its value through FULL and after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_data <= '0;
    end else if (capture) begin
      in_data <= rx_data;
    end
  end

`ifdef IO_TXCOUNT_EN
  // Accepted-pop counter, wrapping naturally at its width.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_count <= '0;
    end else if (tx_pop) begin
      tx_count <= tx_count + TXCOUNT_W'(1);
    end
  end
`endif

endmodule
